latch_load_ctrl: RTL and testbench
==================================

LATCH_LOAD_CTRL -- requirements
Module: latch_load_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the parallel word width (legal 2..16).
REQ-002 SHALL have parameter EN_WIDTH, default 2, the enable pulse length in clocks (legal 1..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sdi  input  1  the serial data bit, MSB first.
REQ-006 SHALL have port sdi_valid  input  1  sdi carries a valid bit this cycle.
REQ-007 SHALL have port sdi_ready  output  1  the block accepts a bit this cycle.
REQ-008 SHALL have port d  output  WIDTH  the registered parallel data to the downstream gate-level D latch bank.
REQ-009 SHALL have port en  output  1  the registered latch-enable strobe to the latch bank.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port load_count  output  8  the number of completed strobes, modulo 256.
REQ-012 SHALL have port perr  output  1  the sticky parity-error flag.

Function
REQ-013 SHALL implement the states IDLE, SHIFT, SETUP, PULSE and HOLD.
REQ-014 SHALL accept a bit on a rising edge only when sdi_valid=1 and sdi_ready=1; shreg <= {shreg[WIDTH-2:0], sdi}.
REQ-015 SHALL drive sdi_ready=1 in IDLE and SHIFT, and 0 in SETUP, PULSE and HOLD.
REQ-016 SHALL, in IDLE, go to SHIFT with bit count 1 on the first accepted bit.
REQ-017 SHALL, in SHIFT, increment the bit count per accepted bit; when sdi_valid=0 it holds count and state indefinitely (no timeout).
REQ-018 SHALL, on the edge accepting the final frame bit, load d with the assembled word and enter SETUP.
REQ-019 SHALL hold SETUP for exactly 1 cycle with en=0, then enter PULSE.
REQ-020 SHALL hold PULSE for exactly EN_WIDTH cycles with en=1, then enter HOLD with en=0.
REQ-021 SHALL hold HOLD for exactly 1 cycle, increment load_count (wrap 255->0) on leaving it, then enter IDLE.
REQ-022 SHALL change d only on entry to SETUP; d stays stable through SETUP, PULSE, HOLD and IDLE until the next load.
REQ-023 SHALL drop sdi_valid while sdi_ready=0 with no effect; no bit is captured or queued.
REQ-024 SHALL give a frame latency from the last-bit edge to the en rising edge of 1 clock (edge N loads d, edge N+1 raises en).
REQ-025 SHALL accept the first bit of the next frame in the IDLE cycle directly after HOLD; there is no back-to-back bypass of IDLE.

Reset
REQ-026 SHALL, on a rising edge with reset=1, enter IDLE and set d=0, en=0, busy=0, load_count=0, perr=0, bit count 0 and shreg 0.
REQ-027 SHALL, on reset during PULSE, deassert en on that same edge; the interrupted strobe does not count.
REQ-028 SHALL give reset priority over every other event on the same edge, including a bit accept.

Configuration
REQ-029 SHALL, with macro LATCH_LOAD_PARITY_EN defined, use a frame of WIDTH+1 bits whose last bit makes the frame's total 1s count even.
REQ-030 SHALL, with LATCH_LOAD_PARITY_EN defined and a parity mismatch, go from SHIFT directly to IDLE, leave d unchanged, skip the strobe, not increment load_count, and set perr until reset.
REQ-031 SHALL, without LATCH_LOAD_PARITY_EN, use a frame of WIDTH bits, keep the perr port present, and tie perr to 0.

Verification
REQ-032 SHALL cover this scenario: WIDTH=8, EN_WIDTH=2, bits 1,0,1,0,0,1,0,1 sent continuously -> d=0xA5 after the 8th-bit edge; en=1 for exactly 2 cycles starting 1 cycle later; busy high 4 cycles; load_count=1.
REQ-033 SHALL cover this scenario: the same frame with sdi_valid=0 for 5 cycles after bit 3 -> identical d=0xA5 and en timing relative to the last bit; no extra bits captured.
REQ-034 SHALL cover this scenario: sdi_valid=1 held through SETUP, PULSE and HOLD -> those bits are ignored; the next frame starts only at IDLE; the second word 0x3C is loaded correctly.
REQ-035 SHALL cover this scenario: reset asserted in the first PULSE cycle -> en=0 and d=0 after that edge; load_count stays 0.
REQ-036 SHALL cover this scenario: 256 back-to-back frames -> load_count wraps to 0; en pulses equal 256.
REQ-037 SHALL cover this scenario: with LATCH_LOAD_PARITY_EN, frame 0xA5 plus parity 1 (odd total) -> no en pulse, d keeps its prior value, perr=1; a following good frame 0x0F plus parity 0 is loaded with perr still 1.

Source files
------------

// File: rtl/latch_load_ctrl.sv
// latch_load_ctrl: serial-to-parallel loader for a gate-level D latch bank.
// Bits arrive MSB first on sdi/sdi_valid. When a frame is complete the
// word is registered onto d. After one setup cycle, en pulses for EN_WIDTH
// clocks, and one hold cycle follows. Then the controller returns to IDLE.
// Optional feature macro: LATCH_LOAD_PARITY_EN. When it is defined, the
// frame gains a trailing even-parity bit and perr becomes a sticky error flag.
module latch_load_ctrl #(
  parameter int WIDTH    = 8,
  parameter int EN_WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             busy,
  output logic [7:0]       load_count,
  output logic             perr
);

`ifdef LATCH_LOAD_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [4:0]       bit_cnt_q;
  logic [2:0]       pulse_cnt_q;
  logic [WIDTH-1:0] d_q;
  logic [7:0]       load_count_q;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept_s;
  logic             last_bit_s;
  logic             pulse_last_s;
  logic             parity_ok_s;
  logic [WIDTH-1:0] word_s;

  // A bit is taken only while the registered ready flag is up.
  assign accept_s     = sdi_valid & ready_q;
  assign last_bit_s   = accept_s && (state_q == SHIFT) && (bit_cnt_q == 5'(FRAME - 1));
  assign pulse_last_s = (pulse_cnt_q == 3'(EN_WIDTH - 1));

`ifdef LATCH_LOAD_PARITY_EN
  logic perr_q;
  // The data bits are already in shreg, and sdi is the parity bit. The total count of 1s must be even.
  assign parity_ok_s = ((^shreg_q) ^ sdi) == 1'b0;
  assign word_s      = shreg_q;
  assign perr        = perr_q;
`else
  logic unused_msb_s;
  assign parity_ok_s  = 1'b1;
  assign word_s       = {shreg_q[WIDTH-2:0], sdi};
  assign unused_msb_s = shreg_q[WIDTH-1];
  assign perr         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A bad-parity frame goes straight back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_s ? SHIFT : IDLE;
      SHIFT: begin
        if (last_bit_s) begin
          state_d = parity_ok_s ? SETUP : IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      SETUP:   state_d = PULSE;
      PULSE:   state_d = pulse_last_s ? HOLD : PULSE;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the flags are registered in step with state_q.
  always_comb begin
    en_d    = (state_d == PULSE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) || (state_d == SHIFT);
  end

  // Output registers. Ready is up in IDLE, so it resets to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      en_q    <= en_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Datapath: shift register, bit and pulse counters, the d word, and the strobe counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q      <= '0;
      bit_cnt_q    <= 5'd0;
      pulse_cnt_q  <= 3'd0;
      d_q          <= '0;
      load_count_q <= 8'd0;
    end else begin
      if (accept_s) begin
        shreg_q <= {shreg_q[WIDTH-2:0], sdi};
      end
      if (accept_s && (state_q == IDLE)) begin
        bit_cnt_q <= 5'd1;
      end else if (last_bit_s) begin
        bit_cnt_q <= 5'd0;
      end else if (accept_s) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
      if (last_bit_s && parity_ok_s) begin
        d_q <= word_s;
      end
      if (state_q == PULSE) begin
        pulse_cnt_q <= pulse_cnt_q + 3'd1;
      end else begin
        pulse_cnt_q <= 3'd0;
      end
      if (state_q == HOLD) begin
        load_count_q <= load_count_q + 8'd1;
      end
    end
  end

`ifdef LATCH_LOAD_PARITY_EN
  // Sticky parity error flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (last_bit_s && !parity_ok_s) begin
      perr_q <= 1'b1;
    end
  end
`endif

  assign sdi_ready  = ready_q;
  assign d          = d_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_latch_load_ctrl.sv
// Directed bench for latch_load_ctrl with WIDTH=8 and EN_WIDTH=2.
module tb_latch_load_ctrl;
  localparam int EN_W = 2;
`ifdef LATCH_LOAD_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sdi = 1'b0;
  logic       sdi_valid = 1'b0;
  logic       sdi_ready;
  logic [7:0] d;
  logic       en;
  logic       busy;
  logic [7:0] load_count;
  logic       perr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulses = 0;
  logic en_prev = 1'b0;

  typedef struct {
    logic       rst;
    logic       sdi;
    logic       vld;
    logic [7:0] d;
    logic       en;
    logic       busy;
    logic       rdy;
    logic [7:0] lc;
  } vec_t;

  vec_t tbl[$];

  latch_load_ctrl #(.WIDTH(8), .EN_WIDTH(EN_W)) dut (
    .clk(clk), .reset(reset), .sdi(sdi), .sdi_valid(sdi_valid),
    .sdi_ready(sdi_ready), .d(d), .en(en), .busy(busy),
    .load_count(load_count), .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // One clock. Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (en && !en_prev) pulses++;
    en_prev = en;
  endtask

  function automatic void push(input logic r, input logic s, input logic v, input logic [7:0] dd,
                               input logic e, input logic b, input logic rd, input logic [7:0] l);
    vec_t x;
    x.rst = r; x.sdi = s; x.vld = v; x.d = dd; x.en = e; x.busy = b; x.rdy = rd; x.lc = l;
    tbl.push_back(x);
  endfunction

  // Frame vectors. Each bit is one cycle, and a gap of invalid cycles may follow a chosen bit.
  // After the frame come the strobe cycles: EN_W PULSE cycles, one HOLD cycle, then IDLE.
  function automatic void push_frame(input logic [7:0] w, input int gap_at, input int gap_len,
                                     input logic junk, input logic [7:0] dprev, input logic [7:0] lc);
    logic [8:0] bits;
    bits = {w, ^w};
    for (int i = 0; i < FRAME; i++) begin
      if (i < FRAME - 1) push(1'b0, bits[8-i], 1'b1, dprev, 1'b0, 1'b1, 1'b1, lc);
      else               push(1'b0, bits[8-i], 1'b1, w,     1'b0, 1'b1, 1'b0, lc);
      if (i + 1 == gap_at)
        for (int g = 0; g < gap_len; g++) push(1'b0, 1'b1, 1'b0, dprev, 1'b0, 1'b1, 1'b1, lc);
    end
    for (int p = 0; p < EN_W; p++) push(1'b0, 1'b1, junk, w, 1'b1, 1'b1, 1'b0, lc);
    push(1'b0, 1'b1, junk, w, 1'b0, 1'b1, 1'b0, lc);
    push(1'b0, 1'b1, junk, w, 1'b0, 1'b0, 1'b1, lc + 8'd1);
  endfunction

  task automatic send_bits(input logic [8:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = bits[8-i];
      sdi_valid = 1'b1;
      step();
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] last_w;
    // The directed table.
    push(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);       // reset state
    push(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'd0);       // reset beats an accept
    push_frame(8'hA5, 0, 0, 1'b0, 8'h00, 8'd0);                  // continuous frame
    push_frame(8'hA5, 3, 5, 1'b0, 8'hA5, 8'd1);                  // 5-cycle gap after bit 3
    push_frame(8'hA5, 0, 0, 1'b1, 8'hA5, 8'd2);                  // valid held through strobe
    push_frame(8'h3C, 0, 0, 1'b0, 8'hA5, 8'd3);                  // next frame right after IDLE

    foreach (tbl[k]) begin
      reset = tbl[k].rst;
      sdi = tbl[k].sdi;
      sdi_valid = tbl[k].vld;
      step();
      chk($sformatf("v%0d.d", k), int'(d), int'(tbl[k].d));
      chk($sformatf("v%0d.en", k), int'(en), int'(tbl[k].en));
      chk($sformatf("v%0d.busy", k), int'(busy), int'(tbl[k].busy));
      chk($sformatf("v%0d.rdy", k), int'(sdi_ready), int'(tbl[k].rdy));
      chk($sformatf("v%0d.lc", k), int'(load_count), int'(tbl[k].lc));
      chk($sformatf("v%0d.perr", k), int'(perr), 0);
    end

    // Reset during the first PULSE cycle.
    reset = 1'b1; sdi_valid = 1'b0; step();
    reset = 1'b0;
    send_bits({8'h3C, ^8'h3C}, FRAME);
    sdi_valid = 1'b0;
    step();
    chk("rstpulse.en_before", int'(en), 1);
    reset = 1'b1; step();
    chk("rstpulse.en", int'(en), 0);
    chk("rstpulse.d", int'(d), 0);
    chk("rstpulse.busy", int'(busy), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rstpulse.idle_en", int'(en), 0);
    end
    chk("rstpulse.lc", int'(load_count), 0);

    // 256 back-to-back frames. Valid stays high, so the bits offered during the strobe are ignored.
    pulses = 0;
    last_w = 8'h00;
    for (int f = 0; f < 256; f++) begin
      w = 8'($urandom_range(0, 255));
      send_bits({w, ^w}, FRAME);
      chk("b2b.d", int'(d), int'(w));
      for (int p = 0; p < EN_W + 2; p++) begin
        sdi = 1'($urandom_range(0, 1));
        sdi_valid = 1'b1;
        step();
      end
      if (f == 254) chk("b2b.lc255", int'(load_count), 255);
      last_w = w;
    end
    sdi_valid = 1'b0;
    chk("b2b.lc_wrap", int'(load_count), 0);
    chk("b2b.pulses", pulses, 256);

`ifdef LATCH_LOAD_PARITY_EN
    // A bad parity bit drops the frame and sets perr. A later good frame still loads.
    pulses = 0;
    send_bits({8'hA5, 1'b1}, FRAME);
    chk("par.busy", int'(busy), 0);
    chk("par.rdy", int'(sdi_ready), 1);
    chk("par.d_kept", int'(d), int'(last_w));
    chk("par.perr", int'(perr), 1);
    sdi_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("par.no_pulse", pulses, 0);
    chk("par.lc", int'(load_count), 0);
    send_bits({8'h0F, 1'b0}, FRAME);
    chk("par.good_d", int'(d), 8'h0F);
    sdi_valid = 1'b0;
    for (int i = 0; i < EN_W + 2; i++) step();
    chk("par.good_pulse", pulses, 1);
    chk("par.good_lc", int'(load_count), 1);
    chk("par.perr_sticky", int'(perr), 1);
`else
    chk("noparity.perr", int'(perr), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
